// File: rtl/issue_scoreboard_if.sv
// Candidate-instruction channel between the instruction queue head and the issue scoreboard.
// The master drives the candidate; the scoreboard (slave) answers with in_ready.
interface issue_scoreboard_if #(
  parameter int NUM_PIPES = 4,
  parameter int REG_WIDTH = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_PIPES-1:0] in_pipe;
  logic [REG_WIDTH-1:0] in_rd;
  logic [REG_WIDTH-1:0] in_rs1;
  logic [REG_WIDTH-1:0] in_rs2;
  logic                 in_rd_write;
  logic                 in_rs1_used;
  logic                 in_rs2_used;

  modport master (
    output in_valid, in_pipe, in_rd, in_rs1, in_rs2,
    output in_rd_write, in_rs1_used, in_rs2_used,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pipe, in_rd, in_rs1, in_rs2,
    input  in_rd_write, in_rs1_used, in_rs2_used,
    output in_ready
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue control for N execution pipes: register scoreboard, write-back slot reservation,
// variable-latency pipe tracking, flush history and a saturating stall counter.
module issue_scoreboard #(
  parameter int                        NUM_REGS     = 32,
  parameter int                        REG_WIDTH    = 5,
  parameter int                        NUM_PIPES    = 4,
  parameter logic [4*NUM_PIPES-1:0]    PIPE_LATENCY = 16'h0321,
  parameter int                        MAX_LATENCY  = 8,
  parameter int                        FLUSH_DEPTH  = 2,
  parameter int                        CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  issue_scoreboard_if.slave    cand,
  input  logic                 wb_en,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [NUM_PIPES-1:0] var_done,
  input  logic                 flush,
  output logic                 issue_valid,
  output logic [NUM_PIPES-1:0] issue_pipe,
  output logic [REG_WIDTH-1:0] issue_rd,
  output logic [REG_WIDTH-1:0] issue_rs1,
  output logic [REG_WIDTH-1:0] issue_rs2,
  output logic [NUM_REGS-1:0]  sb_pending,
  output logic [CNT_WIDTH-1:0] stall_count
);

  logic [NUM_REGS-1:0]  r_pend;
  logic [MAX_LATENCY:0] r_resv;
  logic [FLUSH_DEPTH-1:0] r_hist_vld;
  logic [REG_WIDTH-1:0] r_hist_rd [FLUSH_DEPTH];
  logic                 r_var_pend;
  logic [NUM_PIPES-1:0] r_var_pipe;
  logic                 r_issue_valid;
  logic [NUM_PIPES-1:0] r_issue_pipe;
  logic [REG_WIDTH-1:0] r_issue_rd;
  logic [REG_WIDTH-1:0] r_issue_rs1;
  logic [REG_WIDTH-1:0] r_issue_rs2;
  logic [CNT_WIDTH-1:0] r_stall;

  logic [3:0]           w_lat;
  logic                 w_nop;
  logic                 w_var;
  logic                 w_wbc;
  logic                 w_raw;
  logic                 w_fire;
  logic                 w_ready;
  logic                 w_hist_new;
  logic [NUM_REGS-1:0]  w_set;
  logic [NUM_REGS-1:0]  w_clr;
  logic [NUM_REGS-1:0]  w_pend_next;
  logic [MAX_LATENCY:0] w_resv_next;

  always_comb begin
    w_lat = '0;
    for (int p = 0; p < NUM_PIPES; p++)
      if (cand.in_pipe[p]) w_lat = w_lat | PIPE_LATENCY[4*p +: 4];
    w_nop = ~|cand.in_pipe;
    w_var = !w_nop && (w_lat == 4'd0);

    // A fixed-latency op at L writes back in the same cycle as whatever set R[L] earlier.
    w_wbc = 1'b0;
    for (int l = 1; l <= MAX_LATENCY; l++)
      if (!w_var && w_lat == 4'(l)) w_wbc = w_wbc | r_resv[l];

    w_raw = (cand.in_rs1_used & r_pend[cand.in_rs1]) |
            (cand.in_rs2_used & r_pend[cand.in_rs2]) |
            (cand.in_rd_write & r_pend[cand.in_rd]);

    w_fire  = cand.in_valid & !w_nop & !flush & !w_raw & !w_wbc & !r_var_pend;
    w_ready = w_nop ? (cand.in_valid & !flush) : w_fire;

    w_set = '0;
    if (w_fire && cand.in_rd_write && cand.in_rd != '0) w_set[cand.in_rd] = 1'b1;

    w_clr = '0;
    if (wb_en) w_clr[wb_rd] = 1'b1;
    if (flush)
      for (int i = 0; i < FLUSH_DEPTH; i++)
        if (r_hist_vld[i]) w_clr[r_hist_rd[i]] = 1'b1;

    w_pend_next    = (r_pend & ~w_clr) | w_set;
    w_pend_next[0] = 1'b0;

    w_resv_next = r_resv >> 1;
    for (int l = 1; l <= MAX_LATENCY; l++)
      if (w_fire && !w_var && w_lat == 4'(l)) w_resv_next[l-1] = 1'b1;

    // Only ops that actually claimed their rd are rolled back by a flush.
    w_hist_new = cand.in_rd_write & (cand.in_rd != '0) & !r_pend[cand.in_rd];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend        <= '0;
      r_resv        <= '0;
      r_hist_vld    <= '0;
      for (int i = 0; i < FLUSH_DEPTH; i++) r_hist_rd[i] <= '0;
      r_var_pend    <= 1'b0;
      r_var_pipe    <= '0;
      r_issue_valid <= 1'b0;
      r_issue_pipe  <= '0;
      r_issue_rd    <= '0;
      r_issue_rs1   <= '0;
      r_issue_rs2   <= '0;
      r_stall       <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_resv <= w_resv_next;

      if (flush) begin
        r_hist_vld <= '0;
        for (int i = 0; i < FLUSH_DEPTH; i++) r_hist_rd[i] <= '0;
      end else if (w_fire) begin
        for (int i = FLUSH_DEPTH-1; i > 0; i--) begin
          r_hist_vld[i] <= r_hist_vld[i-1];
          r_hist_rd[i]  <= r_hist_rd[i-1];
        end
        r_hist_vld[0] <= w_hist_new;
        r_hist_rd[0]  <= cand.in_rd;
      end

      if (flush || (|(var_done & r_var_pipe))) begin
        r_var_pend <= 1'b0;
        r_var_pipe <= '0;
      end else if (w_fire && w_var) begin
        r_var_pend <= 1'b1;
        r_var_pipe <= cand.in_pipe;
      end

      r_issue_valid <= w_fire;
      r_issue_pipe  <= cand.in_pipe;
      r_issue_rd    <= cand.in_rd;
      r_issue_rs1   <= cand.in_rs1;
      r_issue_rs2   <= cand.in_rs2;

      if (cand.in_valid && !w_ready && !flush && r_stall != '1)
        r_stall <= r_stall + 1'b1;
    end
  end

  assign cand.in_ready = w_ready;
  assign issue_valid   = r_issue_valid;
  assign issue_pipe    = r_issue_pipe;
  assign issue_rd      = r_issue_rd;
  assign issue_rs1     = r_issue_rs1;
  assign issue_rs2     = r_issue_rs2;
  assign sb_pending    = r_pend;
  assign stall_count   = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a per-cycle vector table plus hand-built
// sequences for variable-latency blocking, flush rollback and asynchronous reset.
module tb_issue_scoreboard;

  localparam logic [15:0] LAT = 16'h0321;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [3:0]  var_done;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_pipe;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic [31:0] sb_pending;
  logic [15:0] stall_count;

  issue_scoreboard_if #(.NUM_PIPES(4), .REG_WIDTH(5)) ifc ();

  issue_scoreboard #(.PIPE_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .cand(ifc),
    .wb_en(wb_en), .wb_rd(wb_rd), .var_done(var_done), .flush(flush),
    .issue_valid(issue_valid), .issue_pipe(issue_pipe),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .sb_pending(sb_pending), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  pipe;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f;      // {rd_write, rs1_used, rs2_used}
    logic        wbe;
    logic [4:0]  wbrd;
    logic [3:0]  vd;
    logic        fl;
    logic        rdy;
    logic        iv;
    logic [31:0] pend;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int step  = 0;
  int exp_stall = 0;
  vec_t tbl [21];

  always @(posedge clk)
    if (!rst && ifc.in_valid)
      assert ($onehot0(ifc.in_pipe)) else $error("in_pipe not one-hot: %b", ifc.in_pipe);

  function automatic vec_t V(logic vld, logic [3:0] pipe, logic [4:0] rd, logic [4:0] rs1,
                             logic [4:0] rs2, logic [2:0] f, logic wbe, logic [4:0] wbrd,
                             logic [3:0] vd, logic fl, logic rdy, logic iv, logic [31:0] pend);
    vec_t v;
    v.vld = vld; v.pipe = pipe; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f = f;
    v.wbe = wbe; v.wbrd = wbrd; v.vd = vd; v.fl = fl;
    v.rdy = rdy; v.iv = iv; v.pend = pend;
    return v;
  endfunction

  function automatic logic [31:0] B(int i);
    return 32'd1 << i;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL step %0d %s: got %0h expected %0h", step, nm, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    ifc.in_valid    = v.vld;
    ifc.in_pipe     = v.pipe;
    ifc.in_rd       = v.rd;
    ifc.in_rs1      = v.rs1;
    ifc.in_rs2      = v.rs2;
    ifc.in_rd_write = v.f[2];
    ifc.in_rs1_used = v.f[1];
    ifc.in_rs2_used = v.f[0];
    wb_en    = v.wbe;
    wb_rd    = v.wbrd;
    var_done = v.vd;
    flush    = v.fl;
    @(negedge clk);
    chk("in_ready", 32'(ifc.in_ready), 32'(v.rdy));
    if (v.vld && !v.rdy && !v.fl) exp_stall++;
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), 32'(v.iv));
    chk("sb_pending", sb_pending, v.pend);
    chk("stall_count", 32'(stall_count), 32'(exp_stall));
    if (v.iv) begin
      chk("issue_rd", 32'(issue_rd), 32'(v.rd));
      chk("issue_pipe", 32'(issue_pipe), 32'(v.pipe));
    end
    step++;
  endtask

  initial begin
    for (int p = 0; p < 4; p++)
      assert (LAT[4*p +: 4] <= 4'd8) else $error("pipe %0d latency above MAX_LATENCY", p);

    // RAW stall on rd=5, released one cycle after its write-back
    tbl[0]  = V(1, 4'b0001,  5,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, B(5));
    tbl[1]  = V(1, 4'b0010,  0,  5,  0, 3'b010, 0,  0, 0, 0, 0, 0, B(5));
    tbl[2]  = V(1, 4'b0010,  0,  5,  0, 3'b010, 0,  0, 0, 0, 0, 0, B(5));
    tbl[3]  = V(1, 4'b0010,  0,  5,  0, 3'b010, 1,  5, 0, 0, 0, 0, 0);
    tbl[4]  = V(1, 4'b0010,  0,  5,  0, 3'b010, 0,  0, 0, 0, 1, 1, 0);
    // write-back slot conflict: pipe2 (L=3) then pipe1 (L=2)
    tbl[5]  = V(1, 4'b0100, 10,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, B(10));
    tbl[6]  = V(1, 4'b0010, 11,  0,  0, 3'b100, 0,  0, 0, 0, 0, 0, B(10));
    tbl[7]  = V(1, 4'b0010, 11,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, B(10) | B(11));
    tbl[8]  = V(1, 4'b0000,  0,  0,  0, 3'b000, 0,  0, 0, 0, 1, 0, B(10) | B(11));
    tbl[9]  = V(0, 4'b0000,  0,  0,  0, 3'b000, 1, 10, 0, 0, 0, 0, B(11));
    tbl[10] = V(0, 4'b0000,  0,  0,  0, 3'b000, 1, 11, 0, 0, 0, 0, 0);
    // x0 is never pending
    tbl[11] = V(1, 4'b0001,  0,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, 0);
    tbl[12] = V(1, 4'b0001,  0,  0,  0, 3'b010, 0,  0, 0, 0, 1, 1, 0);
    // operand-usage flags gate the hazard; WAW blocks; set beats clear
    tbl[13] = V(1, 4'b0001, 12,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, B(12));
    tbl[14] = V(1, 4'b0010, 12,  0, 12, 3'b000, 0,  0, 0, 0, 1, 1, B(12));
    tbl[15] = V(1, 4'b0100,  0,  0, 12, 3'b001, 0,  0, 0, 0, 0, 0, B(12));
    tbl[16] = V(1, 4'b0001, 12,  0,  0, 3'b100, 1, 12, 0, 0, 0, 0, 0);
    tbl[17] = V(1, 4'b0001, 12,  0,  0, 3'b100, 0,  0, 0, 0, 1, 1, B(12));
    tbl[18] = V(0, 4'b0000,  0,  0,  0, 3'b000, 1, 12, 0, 0, 0, 0, 0);
    tbl[19] = V(1, 4'b0001, 13,  0,  0, 3'b100, 1, 13, 0, 0, 1, 1, B(13));
    tbl[20] = V(0, 4'b0000,  0,  0,  0, 3'b000, 1, 13, 0, 0, 0, 0, 0);

    rst = 1'b1;
    ifc.in_valid = 0; ifc.in_pipe = 0; ifc.in_rd = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0;
    ifc.in_rd_write = 0; ifc.in_rs1_used = 0; ifc.in_rs2_used = 0;
    wb_en = 0; wb_rd = 0; var_done = 0; flush = 0;
    #12;
    chk("reset issue_valid", 32'(issue_valid), 0);
    chk("reset sb_pending", sb_pending, 0);
    chk("reset stall_count", 32'(stall_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) cyc(tbl[i]);

    // variable-latency pipe3 blocks everything until its own var_done
    cyc(V(1, 4'b1000, 14, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(14)));
    for (int i = 0; i < 10; i++)
      cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, (i == 4) ? 4'b0001 : 4'b0000, 0, 0, 0, B(14)));
    cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, 4'b1000, 0, 0, 0, B(14)));
    cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, B(14)));
    // flush also releases a variable-latency wait; rd=14 is older than the history window
    cyc(V(1, 4'b1000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, B(14)));
    for (int i = 0; i < 3; i++)
      cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, B(14)));
    cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 0, B(14)));
    cyc(V(1, 4'b0001, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, B(14)));
    cyc(V(0, 4'b0000, 0, 0, 0, 3'b000, 1, 14, 0, 0, 0, 0, 0));

    // flush rolls back the two most recent rds only
    cyc(V(1, 4'b0001, 6, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(6)));
    cyc(V(1, 4'b0001, 7, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(6) | B(7)));
    cyc(V(1, 4'b0001, 8, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(6) | B(7) | B(8)));
    cyc(V(1, 4'b0010, 0, 8, 0, 3'b010, 0, 0, 0, 1, 0, 0, B(6)));
    cyc(V(1, 4'b0010, 0, 8, 0, 3'b010, 0, 0, 0, 0, 1, 1, B(6)));
    cyc(V(0, 4'b0000, 0, 0, 0, 3'b000, 1, 6, 0, 0, 0, 0, 0));

    // asynchronous reset with pending regs, reserved slots and a variable op in flight
    cyc(V(1, 4'b0001, 20, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(20)));
    cyc(V(1, 4'b0100,  0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 1, B(20)));
    cyc(V(1, 4'b1000, 21, 0, 0, 3'b100, 0, 0, 0, 0, 1, 1, B(20) | B(21)));
    #1 rst = 1'b1;
    #1;
    chk("async issue_valid", 32'(issue_valid), 0);
    chk("async sb_pending", sb_pending, 0);
    chk("async stall_count", 32'(stall_count), 0);
    chk("async issue_rd", 32'(issue_rd), 0);
    chk("async issue_pipe", 32'(issue_pipe), 0);
    #1 rst = 1'b0;
    exp_stall = 0;
    cyc(V(1, 4'b0100, 22, 20, 21, 3'b110, 0, 0, 0, 0, 1, 1, B(22)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
